alien_fleet_ctrl: RTL

Formation controller for the 15-alien Space Invaders fleet, replacing the per-alien free-running movers. It sits directly upstream of color_mapper and downstream of missile hit detection. It consumes frame ticks (VGA_VS) and hit events, and produces one fleet origin plus an alive mask. It also produces a march state machine whose speed rises as aliens die and which ends in CLEARED or INVADED.

---
 rtl/invaders_pkg.sv | 29 ++
 rtl/frame_tick_sync.sv | 37 +++
 rtl/alien_fleet_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/invaders_pkg.sv
// -----------------------------------------------------------------------------
// invaders_pkg
// Shared types and constants for the alien fleet formation logic.
//   fleet_state_t : march / terminal states of the fleet controller
//   NUM_ALIENS    : fleet size (FLEET_ROWS x FLEET_COLS)
//   col_of/row_of : alien index -> grid position (index = row*FLEET_COLS + col)
// -----------------------------------------------------------------------------
package invaders_pkg;

   typedef enum logic [1:0] {
      MARCH_R = 2'd0,
      MARCH_L = 2'd1,
      CLEARED = 2'd2,
      INVADED = 2'd3
   } fleet_state_t;

   localparam int NUM_ALIENS = 15;
   localparam int FLEET_COLS = 5;
   localparam int FLEET_ROWS = 3;

   function automatic logic [2:0] col_of(input logic [3:0] idx);
      return 3'(int'(idx) % FLEET_COLS);
   endfunction

   function automatic logic [1:0] row_of(input logic [3:0] idx);
      return 2'(int'(idx) / FLEET_COLS);
   endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// -----------------------------------------------------------------------------
// frame_tick_sync
// Brings the asynchronous frame strobe into the clk domain and turns each
// rising edge into a single-cycle tick.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset
//   async_in : asynchronous level input (VGA vertical sync)
//   tick     : one-cycle pulse, high in the second cycle after the input rises
//              is first sampled, so consumers update on the third clk edge
// -----------------------------------------------------------------------------
module frame_tick_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic tick
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
      end else begin
         sync1_reg <= async_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   // Decoded only from flops, so the pulse is glitch-free.
   assign tick = sync2_reg & ~prev_reg;

endmodule

// File: rtl/alien_fleet_ctrl.sv
// -----------------------------------------------------------------------------
// alien_fleet_ctrl
// Formation controller for the 3x5 alien fleet: one shared origin that marches
// left/right and drops at the screen edges, an alive mask cleared by missile
// hits, and a march rate that speeds up as aliens die.
//   Clk, Reset_n     : clock, asynchronous active-low reset
//   frame_clk        : VGA_VS, asynchronous; each rising edge is a frame tick
//   Restart          : one-cycle pulse, reload the fleet from any state
//   hit_valid/index  : hit strobe and alien index (0-14, others ignored)
//   FleetX/FleetY    : fleet origin; alien i at (X + col*COL_PITCH, Y + row*ROW_PITCH)
//   AliveMask        : bit i = alien i alive
//   FleetState       : MARCH_R / MARCH_L / CLEARED / INVADED
//   Cleared/Invaded  : terminal-state flags
//   Score            : 4-digit BCD kill count when SCORE_EN is defined,
//                      otherwise constant zero
// Optional feature macro: SCORE_EN
// -----------------------------------------------------------------------------
module alien_fleet_ctrl
   import invaders_pkg::*;
#(
   parameter int COL_PITCH        = 40,
   parameter int ROW_PITCH        = 25,
   parameter int ALIEN_W          = 30,
   parameter int ALIEN_H          = 20,
   parameter int START_X          = 100,
   parameter int START_Y          = 40,
   parameter int STEP_X           = 4,
   parameter int STEP_Y           = 10,
   parameter int X_MIN            = 0,
   parameter int X_MAX            = 639,
   parameter int INVADE_Y         = 400,
   parameter int MIN_PERIOD       = 2,
   parameter int PERIOD_PER_ALIEN = 2
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         frame_clk,
   input  logic         Restart,
   input  logic         hit_valid,
   input  logic [3:0]   hit_index,
   output logic [9:0]   FleetX,
   output logic [9:0]   FleetY,
   output logic [14:0]  AliveMask,
   output fleet_state_t FleetState,
   output logic         Cleared,
   output logic         Invaded,
   output logic [15:0]  Score
);

   logic                  frame_tick;
   logic [5:0]            frame_cnt_reg;
   logic [FLEET_COLS-1:0] col_live;
   logic [FLEET_ROWS-1:0] row_live;
   logic [2:0]            leftcol;
   logic [2:0]            rightcol;
   logic [1:0]            botrow;
   logic [3:0]            alive_cnt;
   logic [6:0]            period_m1;
   logic                  step_due;
   logic                  is_march;
   logic [15:0]           mask_ext;
   logic                  hit_live;
   logic [14:0]           mask_next;
   logic [10:0]           right_edge;
   logic [10:0]           left_edge;
   logic [9:0]            drop_y;
   logic [10:0]           bottom_edge;
   logic                  past_right;
   logic                  past_left;
   logic                  invade;

   frame_tick_sync u_tick (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .async_in (frame_clk),
      .tick     (frame_tick)
   );

   // Which columns / rows still hold at least one live alien.
   always_comb begin
      col_live = '0;
      row_live = '0;
      for (int i = 0; i < NUM_ALIENS; i++) begin
         if (AliveMask[i]) begin
            col_live[col_of(4'(i))] = 1'b1;
            row_live[row_of(4'(i))] = 1'b1;
         end
      end
   end

   always_comb begin
      leftcol  = '0;
      rightcol = '0;
      botrow   = '0;
      for (int c = FLEET_COLS - 1; c >= 0; c--)
         if (col_live[c]) leftcol = 3'(c);
      for (int c = 0; c < FLEET_COLS; c++)
         if (col_live[c]) rightcol = 3'(c);
      for (int r = 0; r < FLEET_ROWS; r++)
         if (row_live[r]) botrow = 2'(r);
   end

   assign alive_cnt = 4'($countones(AliveMask));
   assign period_m1 = 7'(MIN_PERIOD) + 7'(alive_cnt) * 7'(PERIOD_PER_ALIEN) - 7'd1;
   assign step_due  = {1'b0, frame_cnt_reg} >= period_m1;
   assign is_march  = (FleetState == MARCH_R) || (FleetState == MARCH_L);

   // Padding bit 15 with zero makes index 15 read as "already dead".
   assign mask_ext  = {1'b0, AliveMask};
   assign hit_live  = hit_valid & mask_ext[hit_index];
   assign mask_next = AliveMask & ~(15'd1 << hit_index);

   // Extent compares are widened to 11 bits so edge sums cannot wrap.
   assign right_edge  = {1'b0, FleetX} + 11'(rightcol) * 11'(COL_PITCH) + 11'(ALIEN_W + STEP_X);
   assign left_edge   = {1'b0, FleetX} + 11'(leftcol) * 11'(COL_PITCH);
   assign past_right  = right_edge > 11'(X_MAX);
   assign past_left   = left_edge < 11'(X_MIN + STEP_X);
   assign drop_y      = FleetY + 10'(STEP_Y);
   assign bottom_edge = {1'b0, drop_y} + 11'(botrow) * 11'(ROW_PITCH) + 11'(ALIEN_H);
   assign invade      = bottom_edge >= 11'(INVADE_Y);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         FleetX        <= 10'(START_X);
         FleetY        <= 10'(START_Y);
         AliveMask     <= 15'h7FFF;
         FleetState    <= MARCH_R;
         frame_cnt_reg <= '0;
         Cleared       <= 1'b0;
         Invaded       <= 1'b0;
      end else if (Restart) begin
         FleetX        <= 10'(START_X);
         FleetY        <= 10'(START_Y);
         AliveMask     <= 15'h7FFF;
         FleetState    <= MARCH_R;
         frame_cnt_reg <= '0;
         Cleared       <= 1'b0;
         Invaded       <= 1'b0;
      end else if (is_march) begin
         if (hit_live)
            AliveMask <= mask_next;
         // Losing the last alien wins over any step in the same cycle.
         if (hit_live && (mask_next == '0)) begin
            FleetState <= CLEARED;
            Cleared    <= 1'b1;
         end else if (frame_tick) begin
            if (step_due) begin
               frame_cnt_reg <= '0;
               if (FleetState == MARCH_R) begin
                  if (past_right) begin
                     FleetY <= drop_y;
                     if (invade) begin
                        FleetState <= INVADED;
                        Invaded    <= 1'b1;
                     end else begin
                        FleetState <= MARCH_L;
                     end
                  end else begin
                     FleetX <= FleetX + 10'(STEP_X);
                  end
               end else begin
                  if (past_left) begin
                     FleetY <= drop_y;
                     if (invade) begin
                        FleetState <= INVADED;
                        Invaded    <= 1'b1;
                     end else begin
                        FleetState <= MARCH_R;
                     end
                  end else begin
                     FleetX <= FleetX - 10'(STEP_X);
                  end
               end
            end else begin
               frame_cnt_reg <= frame_cnt_reg + 6'd1;
            end
         end
      end
   end

`ifdef SCORE_EN
   // BCD ripple increment; the carry out of the top digit means 9999,
   // which doubles as the saturation condition.
   logic [15:0] score_inc;
   logic [4:0]  bcd_carry;

   assign bcd_carry[0] = 1'b1;

   for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
      logic digit_nine;
      assign digit_nine         = (Score[gi*4 +: 4] == 4'd9);
      assign score_inc[gi*4 +: 4] = !bcd_carry[gi] ? Score[gi*4 +: 4] :
                                    digit_nine      ? 4'd0 :
                                                      Score[gi*4 +: 4] + 4'd1;
      assign bcd_carry[gi+1]    = bcd_carry[gi] & digit_nine;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         Score <= 16'h0000;
      else if (Restart)
         Score <= 16'h0000;
      else if (is_march && hit_live && !bcd_carry[4])
         Score <= score_inc;
   end
`else
   assign Score = 16'h0000;
`endif

endmodule
